// File: rtl/ahb_pkg.sv
// AHB-Lite bus encodings and the state type of the SRAM responder.
// Imported by the SRAM slave and its lane-strobe helper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DONE,
        ERR1,
        ERR2
    } ahb_state_e;

endpackage

// File: rtl/ahb_lane_strobe.sv
// Little-endian byte-lane strobe for a 32-bit AHB data bus.
// Flags sizes above a word and misaligned half/word accesses.
module ahb_lane_strobe
    import ahb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] strobe,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        strobe  = 4'b0000;
        illegal = 1'b0;
        case (hsize)
            HSIZE_BYTE: strobe = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                if (addr_lo[0]) illegal = 1'b1;
                else            strobe  = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            HSIZE_WORD: begin
                if (addr_lo != 2'b00) illegal = 1'b1;
                else                  strobe  = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: programmable wait states, byte-lane writes,
// and the two-cycle ERROR response for misaligned, oversized or out-of-range transfers.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

    ahb_state_e    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]    strb_q, strb_d;
    logic          write_q, write_d;
    logic          hreadyout_q, hreadyout_d;
    logic          hresp_q, hresp_d;

    logic          is_xfer;
    logic          accept;
    logic [AW-1:0] addr_idx;
    logic [3:0]    lane_strb;
    logic          lane_err;
    logic          range_err;
    logic          addr_err;
    logic          data_done;
    logic          unused_inputs;

    logic [31:0]   mem [DEPTH];

    ahb_lane_strobe u_lane_strobe (
        .hsize   (hsize),
        .addr_lo (haddr[1:0]),
        .strobe  (lane_strb),
        .illegal (lane_err)
    );

    always_comb begin
        is_xfer = 1'b0;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: is_xfer = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  is_xfer = 1'b0;
            default:                   is_xfer = 1'b0;
        endcase
    end

    assign accept    = hsel && is_xfer && hready;
    assign addr_idx  = haddr[AW+1:2];
    assign range_err = {1'b0, addr_idx} >= (AW+1)'(DEPTH);
    assign addr_err  = lane_err || range_err;

    // pend_q is set only for OKAY transfers, so it plus ready marks the completing cycle.
    assign data_done = pend_q && hreadyout_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        idx_d       = idx_q;
        strb_d      = strb_q;
        write_d     = write_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        unique case (state_q)
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = DONE;
                    hreadyout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ERR1: begin
                state_d     = ERR2;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_ERROR;
            end
            default: begin
                // IDLE, DONE and ERR2 all present ready and may take a new address phase.
                state_d     = IDLE;
                pend_d      = 1'b0;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
                if (accept) begin
                    idx_d   = addr_idx;
                    strb_d  = lane_strb;
                    write_d = hwrite;
                    if (addr_err) begin
                        state_d     = ERR1;
                        hreadyout_d = 1'b0;
                        hresp_d     = HRESP_ERROR;
                    end else if (WAIT_STATES > 0) begin
                        state_d     = WAIT;
                        cnt_d       = WAIT_LOAD;
                        pend_d      = 1'b1;
                        hreadyout_d = 1'b0;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            pend_q      <= 1'b0;
            idx_q       <= '0;
            strb_q      <= 4'b0000;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            idx_q       <= idx_d;
            strb_q      <= strb_d;
            write_q     <= write_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // NOTE: the memory array has no reset; contents survive reset and only the control path is cleared.
    always_ff @(posedge clk) begin
        if (data_done && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_q[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    assign hrdata    = (data_done && !write_q) ? mem[idx_q] : 32'h0;
    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;

    assign unused_inputs = ^{hprot, haddr[31:AW+2]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Three ahb_sram_slave instances on one AHB-Lite bus with a data-phase mux;
// a pipelined bus driver checks every cycle against table and reference-model expectations.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    localparam int D0 = 1000, D1 = 1024, D2 = 1024;
    localparam int W0 = 0,    W1 = 2,    W2 = 3;

    typedef struct {
        int          id;
        int          slv;
        logic        hsel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic        chk_rdata;
    } vec_t;

    int depth_of [3] = '{D0, D1, D2};
    int ws_of    [3] = '{W0, W1, W2};
    int aw_of    [3] = '{$clog2(D0), $clog2(D1), $clog2(D2)};

    logic        clk;
    logic        rst_n;
    logic        b_hsel;
    int          b_slv;
    logic [1:0]  b_trans;
    logic [31:0] b_addr;
    logic [2:0]  b_size;
    logic        b_write;
    logic [3:0]  b_prot;
    logic [31:0] b_wdata;

    logic [2:0]  ho;
    logic [2:0]  hr;
    logic [31:0] hd [3];
    int          dsel;
    logic        hready;
    logic        b_hresp;
    logic [31:0] b_hrdata;

    int tests;
    int failures;

    vec_t        vq [$];
    logic [31:0] mdl [int];

    ahb_sram_slave #(.DEPTH(D0), .WAIT_STATES(W0)) u_s0 (
        .clk(clk), .reset(rst_n), .hsel(b_hsel && (b_slv == 0)), .haddr(b_addr),
        .htrans(b_trans), .hwrite(b_write), .hsize(b_size), .hprot(b_prot),
        .hwdata(b_wdata), .hready(hready), .hreadyout(ho[0]), .hresp(hr[0]), .hrdata(hd[0])
    );
    ahb_sram_slave #(.DEPTH(D1), .WAIT_STATES(W1)) u_s1 (
        .clk(clk), .reset(rst_n), .hsel(b_hsel && (b_slv == 1)), .haddr(b_addr),
        .htrans(b_trans), .hwrite(b_write), .hsize(b_size), .hprot(b_prot),
        .hwdata(b_wdata), .hready(hready), .hreadyout(ho[1]), .hresp(hr[1]), .hrdata(hd[1])
    );
    ahb_sram_slave #(.DEPTH(D2), .WAIT_STATES(W2)) u_s2 (
        .clk(clk), .reset(rst_n), .hsel(b_hsel && (b_slv == 2)), .haddr(b_addr),
        .htrans(b_trans), .hwrite(b_write), .hsize(b_size), .hprot(b_prot),
        .hwdata(b_wdata), .hready(hready), .hreadyout(ho[2]), .hresp(hr[2]), .hrdata(hd[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Response mux: the slave owning the current data phase drives the bus.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dsel <= 0;
        else if (hready) dsel <= b_slv;
    end
    assign hready   = ho[dsel];
    assign b_hresp  = hr[dsel];
    assign b_hrdata = hd[dsel];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
    endtask

    function automatic vec_t mk(input int slv, input logic hsel, input logic [1:0] trans,
                                input logic [31:0] addr, input logic [2:0] size, input logic write,
                                input logic [31:0] wdata, input logic exp_err,
                                input logic [31:0] exp_rdata, input logic chk);
        vec_t v;
        v.id = 0; v.slv = slv; v.hsel = hsel; v.trans = trans; v.addr = addr; v.size = size;
        v.write = write; v.wdata = wdata; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        v.chk_rdata = chk;
        return v;
    endfunction

    // Reference model: word-addressed byte memory per slave, rules applied in issue order.
    function automatic vec_t model(input vec_t v);
        int          idx, key, nb, st;
        logic [31:0] w;
        v.exp_err = 1'b0; v.exp_rdata = 32'h0; v.chk_rdata = 1'b0;
        if (!(v.hsel && v.trans[1])) return v;
        idx = int'(v.addr[31:2] % (32'd1 << aw_of[v.slv]));
        if (v.size > 3'd2 || (v.size == 3'd1 && v.addr[0]) ||
            (v.size == 3'd2 && v.addr[1:0] != 2'd0) || idx >= depth_of[v.slv]) begin
            v.exp_err = 1'b1;
            return v;
        end
        key = v.slv * 4096 + idx;
        if (v.write) begin
            nb = 1 << v.size;
            st = int'(v.addr[1:0]);
            if (nb == 4 || mdl.exists(key)) begin
                w = mdl.exists(key) ? mdl[key] : 32'h0;
                for (int b = st; b < st + nb; b++) w[8*b +: 8] = v.wdata[8*b +: 8];
                mdl[key] = w;
            end
        end else if (mdl.exists(key)) begin
            v.chk_rdata = 1'b1;
            v.exp_rdata = mdl[key];
        end
        return v;
    endfunction

    task automatic drive_addr(input vec_t v, input bit valid);
        if (valid) begin
            b_slv = v.slv; b_hsel = v.hsel; b_trans = v.trans; b_addr = v.addr;
            b_size = v.size; b_write = v.write;
        end else begin
            b_hsel = 1'b0; b_trans = HTRANS_IDLE; b_addr = $urandom;
            b_size = HSIZE_WORD; b_write = 1'b0;
        end
    endtask

    // Pipelined master: address of N+1 overlaps data phase of N, advancing only on hready.
    task automatic run_queue();
        vec_t        ap, dp;
        bit          ap_v, dp_v, rdy, chk_rd;
        int          c;
        logic        exp_rdy, exp_resp;
        logic [31:0] exp_rd;
        ap_v = 1'b0; dp_v = 1'b0; c = 0;
        ap = mk(0, 0, HTRANS_IDLE, 0, 0, 0, 0, 0, 0, 0);
        dp = ap;
        if (vq.size() > 0) begin ap = vq.pop_front(); ap_v = 1'b1; end
        drive_addr(ap, ap_v);
        while (ap_v || dp_v) begin
            @(negedge clk);
            if (dp_v && dp.exp_err) begin
                exp_rdy = (c >= 1); exp_resp = 1'b1; exp_rd = 32'h0; chk_rd = 1'b1;
            end else if (dp_v) begin
                exp_rdy  = (c >= ws_of[dp.slv]);
                exp_resp = 1'b0;
                chk_rd   = !(exp_rdy && !dp.write && !dp.chk_rdata);
                exp_rd   = (exp_rdy && !dp.write) ? dp.exp_rdata : 32'h0;
            end else begin
                exp_rdy = 1'b1; exp_resp = 1'b0; exp_rd = 32'h0; chk_rd = 1'b1;
            end
            check($sformatf("v%0d c%0d hready", dp_v ? dp.id : -1, c), 32'(hready), 32'(exp_rdy));
            check($sformatf("v%0d c%0d hresp", dp_v ? dp.id : -1, c), 32'(b_hresp), 32'(exp_resp));
            if (chk_rd) check($sformatf("v%0d c%0d hrdata", dp_v ? dp.id : -1, c), b_hrdata, exp_rd);
            rdy = hready;
            @(posedge clk); #1;
            if (rdy) begin
                dp_v = ap_v && ap.hsel && ap.trans[1];
                dp   = ap;
                c    = 0;
                ap_v = 1'b0;
                if (vq.size() > 0) begin ap = vq.pop_front(); ap_v = 1'b1; end
                drive_addr(ap, ap_v);
                b_wdata = dp_v ? dp.wdata : $urandom;
            end else begin
                c++;
                if (c > 40) begin
                    tests++; failures++;
                    $display("FAIL timeout v%0d: hready low for %0d cycles, expected high", dp.id, c);
                    summary();
                    $finish;
                end
            end
        end
    endtask

    task automatic push_vec(input vec_t v);
        vec_t m;
        v.id = tests + vq.size() + 1000 * (vq.size() / 1000);
        m = model(v);
        vq.push_back(v);
    endtask

    initial begin
        vec_t        dir_tbl [$];
        vec_t        v;
        int          s, idx, r;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [1:0]  tr;

        tests = 0; failures = 0;
        rst_n = 1'b0; b_slv = 0; b_prot = 4'b0011; b_wdata = 32'h0;
        drive_addr(mk(0, 0, HTRANS_IDLE, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset s%0d hreadyout", i), 32'(ho[i]), 32'h1);
            check($sformatf("reset s%0d hresp", i), 32'(hr[i]), 32'h0);
            check($sformatf("reset s%0d hrdata", i), hd[i], 32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors: {slave, hsel, htrans, haddr, hsize, hwrite, hwdata, err, rdata, check}.
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'h0,   HSIZE_WORD, 1, 32'h12345678, 0, 0, 0));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'h4,   HSIZE_WORD, 1, 32'h87654321, 0, 0, 0));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'h0,   HSIZE_WORD, 0, 0, 0, 32'h12345678, 1));
        dir_tbl.push_back(mk(0, 1, HTRANS_SEQ,    32'h4,   HSIZE_WORD, 0, 0, 0, 32'h87654321, 1));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'h8,   HSIZE_WORD, 1, 32'hCAFEBABE, 0, 0, 0));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'hA,   HSIZE_BYTE, 1, 32'hEE11EEEE, 0, 0, 0));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'h8,   HSIZE_HALF, 1, 32'hEEEE3344, 0, 0, 0));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'h8,   HSIZE_WORD, 0, 0, 0, 32'hCA113344, 1));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'h2,   HSIZE_WORD, 0, 0, 1, 0, 0));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'h2,   HSIZE_WORD, 1, 32'hFFFFFFFF, 1, 0, 0));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'h0,   3'b011,     0, 0, 1, 0, 0));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'h8,   3'b011,     1, 32'hFFFFFFFF, 1, 0, 0));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'hFA0, HSIZE_WORD, 1, 32'hFFFFFFFF, 1, 0, 0));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'h1,   HSIZE_HALF, 0, 0, 1, 0, 0));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'h4,   HSIZE_WORD, 0, 0, 0, 32'h87654321, 1));
        dir_tbl.push_back(mk(0, 1, HTRANS_IDLE,   32'h0,   HSIZE_WORD, 1, 32'hFFFFFFFF, 0, 0, 0));
        dir_tbl.push_back(mk(0, 1, HTRANS_BUSY,   32'h0,   HSIZE_WORD, 1, 32'hFFFFFFFF, 0, 0, 0));
        dir_tbl.push_back(mk(0, 0, HTRANS_NONSEQ, 32'h0,   HSIZE_WORD, 1, 32'hFFFFFFFF, 0, 0, 0));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'h0,   HSIZE_WORD, 0, 0, 0, 32'h12345678, 1));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'h8,   HSIZE_WORD, 0, 0, 0, 32'hCA113344, 1));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'hC,   HSIZE_WORD, 1, 32'h55AA55AA, 0, 0, 0));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'hC,   HSIZE_WORD, 0, 0, 0, 32'h55AA55AA, 1));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'hFA0, HSIZE_WORD, 0, 0, 1, 0, 0));
        dir_tbl.push_back(mk(1, 1, HTRANS_NONSEQ, 32'h10,  HSIZE_WORD, 1, 32'h01020304, 0, 0, 0));
        dir_tbl.push_back(mk(1, 1, HTRANS_NONSEQ, 32'h10,  HSIZE_WORD, 0, 0, 0, 32'h01020304, 1));
        dir_tbl.push_back(mk(1, 1, HTRANS_NONSEQ, 32'h10,  HSIZE_WORD, 0, 0, 0, 32'h01020304, 1));
        dir_tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'h4,   HSIZE_WORD, 0, 0, 0, 32'h87654321, 1));
        dir_tbl.push_back(mk(1, 1, HTRANS_NONSEQ, 32'h6,   HSIZE_WORD, 0, 0, 1, 0, 0));
        dir_tbl.push_back(mk(2, 1, HTRANS_NONSEQ, 32'h20,  HSIZE_WORD, 1, 32'h0BADF00D, 0, 0, 0));
        dir_tbl.push_back(mk(1, 1, HTRANS_NONSEQ, 32'h10,  HSIZE_WORD, 0, 0, 0, 32'h01020304, 1));
        dir_tbl.push_back(mk(2, 1, HTRANS_NONSEQ, 32'h20,  HSIZE_WORD, 0, 0, 0, 32'h0BADF00D, 1));
        dir_tbl.push_back(mk(2, 1, HTRANS_NONSEQ, 32'h40,  HSIZE_WORD, 1, 32'hA5A5A5A5, 0, 0, 0));

        for (int i = 0; i < dir_tbl.size(); i++) begin
            v = dir_tbl[i];
            v.id = i;
            void'(model(v));
            vq.push_back(v);
        end
        run_queue();

        // Randomized traffic over a small word pool, checked against the model.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 3; k++) begin
                v = model(mk(k, 1, HTRANS_NONSEQ, 32'(i * 4), HSIZE_WORD, 1, $urandom, 0, 0, 0));
                v.id = 100 + i * 3 + k;
                vq.push_back(v);
            end
        end
        for (int i = 0; i < 300; i++) begin
            s   = $urandom_range(0, 2);
            idx = $urandom_range(0, 7);
            if (s == 0 && $urandom_range(0, 4) == 0) idx = 1000 + $urandom_range(0, 23);
            r = $urandom_range(0, 9);
            if (r < 3)      sz = HSIZE_BYTE;
            else if (r < 6) sz = HSIZE_HALF;
            else if (r < 9) sz = HSIZE_WORD;
            else            sz = 3'($urandom_range(3, 7));
            a = $urandom;
            a[11:2] = 10'(idx);
            if ($urandom_range(0, 5) != 0) begin
                if (sz == HSIZE_WORD)      a[1:0] = 2'b00;
                else if (sz == HSIZE_HALF) a[0]   = 1'b0;
            end
            r  = $urandom_range(0, 9);
            tr = (r < 8) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
            v = model(mk(s, ($urandom_range(0, 9) != 0), tr, a, sz, 1'($urandom_range(0, 1)),
                         $urandom, 0, 0, 0));
            v.id = 200 + i;
            vq.push_back(v);
        end
        run_queue();

        // Reset in the middle of a WAIT_STATES=3 write: pending write is dropped.
        b_slv = 2; b_hsel = 1'b1; b_trans = HTRANS_NONSEQ; b_addr = 32'h40;
        b_size = HSIZE_WORD; b_write = 1'b1;
        @(posedge clk); #1;
        drive_addr(mk(0, 0, HTRANS_IDLE, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        b_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("rstwait s2 hreadyout low", 32'(ho[2]), 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstmid s2 hreadyout", 32'(ho[2]), 32'h1);
        check("rstmid s2 hresp", 32'(hr[2]), 32'h0);
        check("rstmid s2 hrdata", hd[2], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        v = mk(2, 1, HTRANS_NONSEQ, 32'h40, HSIZE_WORD, 0, 0, 0, 32'hA5A5A5A5, 1);
        v.id = 900;
        vq.push_back(v);
        run_queue();

        summary();
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite responder that completes the transfers our AHB master issues: it accepts address phases, inserts a programmable number of wait states, and returns read data or commits write data with byte-lane strobes. It also returns the two-cycle ERROR response for illegal transfers. It sits behind the address decoder (`hsel`) and feeds the response mux (`hreadyout`, `hresp`, `hrdata`), as the RAM-side slave.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words, ≥2, need not be a power of two; `AW = $clog2(DEPTH)`.
- `WAIT_STATES`, 0: wait cycles inserted in every OKAY data phase, 0..15.
- `clk` input 1: the single clock, rising edge.
- `reset` input 1: reset, asynchronous, active-low.
- `hsel` input 1: slave select from the decoder.
- `haddr` input 32: byte address. Word index is `haddr[AW+1:2]`; upper bits are ignored.
- `htrans` input 2: transfer type. IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `hwrite` input 1: 1 = write.
- `hsize` input 3: transfer size. 000 = byte, 001 = half, 010 = word.
- `hprot` input 4: protection attribute; accepted and ignored.
- `hwdata` input 32: write data, valid in the data phase.
- `hready` input 1: bus-wide ready from the mux.
- `hreadyout` output 1: this slave's ready.
- `hresp` output 1: 0 = OKAY, 1 = ERROR.
- `hrdata` output 32: read data.

## Operation
- **Accept:** an address phase is accepted on a rising edge where `hsel & htrans[1] & hready` is true. It captures word index, byte offset, size, direction and error flag.
- **IDLE/BUSY:** an IDLE or BUSY transfer, or `hsel=0`, gets a zero-wait OKAY.
- **Error conditions**, evaluated in the address phase:
  - `hsize > 010`;
  - half access with `haddr[0]=1`;
  - word access with `haddr[1:0]!=0`;
  - word index ≥ `DEPTH`.
- **Errored transfer:** memory is not written, `hrdata` stays 0, and no wait states are inserted.
- **Write lanes (little-endian):**
  - byte writes lane `haddr[1:0]`;
  - half writes lanes {0,1} or {2,3} per `haddr[1]`;
  - word writes all four lanes.
- **Write commit:** the memory write uses `hwdata` on the edge that completes the data phase (`hreadyout=1`, OKAY).
- **Read data:**
  - `hrdata` is the full 32-bit word `mem[idx_q]`, combinational from the registered index, driven only in the completing cycle of an OKAY read data phase; otherwise it is 0.
  - The master extracts lanes.
- **Read-after-write:** a read immediately after a write to the same word returns the new data, because the write commits before the read's data phase.
- **State machine:**
  - `IDLE`: `hreadyout=1`, `hresp=0`. On accept:
    - to `ERR1` if the error flag is set;
    - else to `WAIT` if `WAIT_STATES>0`;
    - else stay in `IDLE` with the data phase completing next cycle.
    - A pending data-phase flag marks completion.
  - `WAIT`: `hreadyout=0`, `hresp=0`. A 4-bit counter loads `WAIT_STATES-1` on accept and decrements each cycle. At 0, go to `DONE`.
  - `DONE`: `hreadyout=1`, `hresp=0`; the data phase completes. A new accept is handled as in `IDLE`; otherwise go to `IDLE`.
  - `ERR1`: `hreadyout=0`, `hresp=1`; always go to `ERR2`.
  - `ERR2`: `hreadyout=1`, `hresp=1`. A new address phase presented here (`hready=1`) is accepted, as in `IDLE`.
- **Reset mid-operation:** any state goes to `IDLE`, the pending transfer is dropped and no write occurs. Memory contents are not reset.

## Timing
- **Reset values:** `hreadyout=1`, `hresp=0`, `hrdata=0`, state `IDLE`, counter 0, pending flag 0.
- **Latency:** the OKAY data phase lasts `1+WAIT_STATES` cycles after the accepting edge. An ERROR lasts exactly 2 cycles.
- **Back-to-back:** with `WAIT_STATES=0` the slave supports back-to-back transfers at full rate; the address phase of N+1 overlaps the data phase of N.
- **Bus held by another slave:** while `hready=0` driven by another slave, no accept occurs and the state holds.
- **Sampling:** all outputs are registered state decodes except `hrdata`, which is mux-combinational from registered index and memory.

## Structure
- **Package `ahb_pkg`:**
  - `HTRANS_IDLE/BUSY/NONSEQ/SEQ`;
  - `HSIZE_BYTE/HALF/WORD`;
  - `HRESP_OKAY/ERROR`;
  - the state enum `{IDLE, WAIT, DONE, ERR1, ERR2}`.
- **Sub-module `ahb_lane_strobe`:** combinational; takes `hsize` and `haddr[1:0]` and outputs the 4-bit lane strobe and a misaligned/illegal flag. It is shared with future AHB slaves.
- **Memory:** a reg array with a per-lane write enable.

## Test plan
- **Reset:** drive `reset=0` mid-`WAIT` with `WAIT_STATES=3` → next edge `hreadyout=1`, `hresp=0`, `hrdata=0`; target word unchanged.
- **Word write/read:** NONSEQ word write of 0x12345678 to 0x0, then NONSEQ word write of 0x87654321 to 0x4, then reads of 0x0 and 0x4. With `WAIT_STATES=0` → reads return 0x12345678 and 0x87654321 with no wait cycles.
- **Byte/half lanes:** word write 0xCAFEBABE to 0x8, byte write 0x11 to 0xA, half write 0x3344 to 0x8 → read of 0x8 returns 0xCA113344.
- **Wait states:** with `WAIT_STATES=2`, read → `hreadyout` low for exactly 2 cycles, then high with valid data. Back-to-back reads keep `hready` low, and the second address is not accepted until the first completes.
- **Errors:**
  - word access at 0x2 → `hresp=1` for 2 cycles, `hreadyout` sequence 0,1, memory unchanged;
  - `hsize=011` → same response;
  - index ≥ `DEPTH` (`DEPTH=1000`, addr 0xFA0) → same response.
- **Idle/busy/unselected:** IDLE, BUSY and `hsel=0` cycles interleaved with transfers → OKAY, `hreadyout=1`, no memory change. A transfer issued during `ERR2` is accepted and completes normally.
